sync_fifo_param: RTL

Parametrised single-clock FIFO. It is the successor to the fixed 16x32 SPI/GPIO buffer: depth and width are configurable, and it adds simultaneous read+write, a fill-level output, programmable almost-full/almost-empty flags, sticky overflow and underflow flags, and a synchronous flush. It sits between the bus-side register interface and the SPI shift engine, as TX and RX instances.

---
 rtl/sync_fifo_param_pkg.sv | 24 ++
 rtl/fifo_dpram.sv | 40 ++++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 3 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised FIFO and the SPI status register map.
// Status-bit positions are consumed by the register block, not by the FIFO itself.
package sync_fifo_param_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  localparam int unsigned StatBitOv    = 0;
  localparam int unsigned StatBitUf    = 1;
  localparam int unsigned StatBitAf    = 2;
  localparam int unsigned StatBitAe    = 3;
  localparam int unsigned StatBitFull  = 4;
  localparam int unsigned StatBitEmpty = 5;

endpackage

// File: rtl/fifo_dpram.sv
// FIFODEPTH x FIFOWIDTH storage: one write port, one registered read port.
// Only the read register is reset; the array stays reset-free so it can map onto RAM.
module fifo_dpram
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned FIFODEPTH = 16,
  parameter int unsigned FIFOWIDTH = 32,
  localparam int unsigned ADDRW    = clog2(FIFODEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [ADDRW-1:0]     wr_addr_i,
  input  logic [FIFOWIDTH-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDRW-1:0]     rd_addr_i,
  output logic [FIFOWIDTH-1:0] rd_data_o
);

  logic [FIFOWIDTH-1:0] mem_q [FIFODEPTH];
  logic [FIFOWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Same-address read+write returns the old word, which is what a pop from a full FIFO needs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level, almost-full/empty thresholds,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned FIFODEPTH  = 16,
  parameter int unsigned FIFOWIDTH  = 32,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 4,
  localparam int unsigned ADDRW     = clog2(FIFODEPTH)
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Write,
  input  logic                 Read,
  input  logic                 Flush,
  input  logic                 ClearOV,
  input  logic                 ClearUF,
  input  logic [FIFOWIDTH-1:0] DataIn,
  output logic [FIFOWIDTH-1:0] DataOut,
  output logic                 Full,
  output logic                 Empty,
  output logic                 AlmostFull,
  output logic                 AlmostEmpty,
  output logic [ADDRW:0]       Level,
  output logic                 OV,
  output logic                 UF,
  output logic [ADDRW-1:0]     ReadPtr,
  output logic [ADDRW-1:0]     WritePtr
);

  localparam logic [ADDRW:0] LvlFull = (ADDRW + 1)'(FIFODEPTH);
  localparam logic [ADDRW:0] LvlAf   = (ADDRW + 1)'(AFULL_LVL);
  localparam logic [ADDRW:0] LvlAe   = (ADDRW + 1)'(AEMPTY_LVL);

  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW:0]   level_q, level_d;
  logic             ov_q, ov_d;
  logic             uf_q, uf_d;
  logic             full, empty;
  logic             push, pop, ov_set, uf_set;

  assign full  = (level_q == LvlFull);
  assign empty = (level_q == '0);

  // A pop on a full FIFO frees the slot the same cycle, so the push is still accepted.
  assign push   = Write & ~Flush & (~full | Read);
  assign pop    = Read & ~Flush & ~empty;
  assign ov_set = Write & ~Flush & full & ~Read;
  assign uf_set = Read & ~Flush & empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
    ov_d = ov_set | (ov_q & ~ClearOV);
    uf_d = uf_set | (uf_q & ~ClearUF);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ov_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ov_q     <= ov_d;
      uf_q     <= uf_d;
    end
  end

  fifo_dpram #(
    .FIFODEPTH(FIFODEPTH),
    .FIFOWIDTH(FIFOWIDTH)
  ) u_mem (
    .clk_i    (Clock),
    .rst_ni   (Reset_n),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(DataIn),
    .rd_en_i  (pop),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(DataOut)
  );

  assign Full        = full;
  assign Empty       = empty;
  assign AlmostFull  = (level_q >= LvlAf);
  assign AlmostEmpty = (level_q <= LvlAe);
  assign Level       = level_q;
  assign OV          = ov_q;
  assign UF          = uf_q;
  assign ReadPtr     = rd_ptr_q;
  assign WritePtr    = wr_ptr_q;

endmodule
